dap_arbiter_n: RTL and testbench

Parametrised debug-access-port arbiter and capture stage. It selects one of NCH debug buses, registers that bus's word onto the DCP output, and reports the winning channel index on SEL. Delivery to the downstream debug consumer uses a valid/ready handshake. Supports fixed-priority or round-robin arbitration, channel lock for burst capture, and a bounded lock length.

---
 rtl/dap_arbiter_n.sv | 139 +++++++++++++
 tb/tb_dap_arbiter_n.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dap_arbiter_n.sv
// Debug-access-port arbiter and capture stage.
// Selects one of NCH debug buses and registers its word onto DCP with the
// winning index on SEL. The word is offered to the consumer over a
// valid/ready handshake. Arbitration is either fixed priority or
// round-robin. An optional channel lock keeps the grant on one channel,
// but only for a bounded number of consecutive beats.
module dap_arbiter_n #(
  parameter int NCH      = 4,
  parameter int DW       = 32,
  parameter int SELW     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              MRST,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] DB,
  input  logic              mode,
  input  logic              lock,
  output logic [DW-1:0]     DCP,
  output logic [SELW-1:0]   SEL,
  output logic              dcp_valid,
  input  logic              dcp_ready,
  output logic [NCH-1:0]    grant
);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

  state_t          state_q, state_d;
  logic [DW-1:0]   dcp_q, dcp_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [7:0]      hold_q, hold_d;

  logic [SELW:0]   pick;
  logic [SELW-1:0] nextPtr;
  logic [SELW-1:0] rrBase;
  logic [NCH-1:0]  others;
  logic [NCH-1:0]  arbMask;

  // Returns {found, index}. In round-robin mode the scan starts at ptr and
  // wraps past NCH-1 back to 0; otherwise the lowest set index wins.
  function automatic logic [SELW:0] arbPick(input logic [NCH-1:0] mask,
                                            input logic rr,
                                            input logic [SELW-1:0] ptr);
    logic            found;
    logic [SELW-1:0] win;
    int              idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = rr ? ((int'(ptr) + k) % NCH) : k;
      if (!found && mask[idx]) begin
        found = 1'b1;
        win   = SELW'(idx);
      end
    end
    return {found, win};
  endfunction

  // Next-state logic: arbitration on entry from IDLE and on every completed
  // transfer, with lock recapture taking precedence while the budget lasts.
  always_comb begin
    state_d = state_q;
    dcp_d   = dcp_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    pick    = '0;
    rrBase  = ptr_q;
    nextPtr = (sel_q == SELW'(NCH - 1)) ? '0 : sel_q + 1'b1;
    others  = req & ~(NCH'(1) << sel_q);
    arbMask = req;

    case (state_q)
      IDLE: begin
        pick = arbPick(req, mode, ptr_q);
        if (pick[SELW]) begin
          sel_d   = pick[SELW-1:0];
          dcp_d   = DB[int'(pick[SELW-1:0])*DW +: DW];
          hold_d  = 8'd1;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (dcp_ready) begin
          if (lock && req[sel_q] && (hold_q < MaxHold)) begin
            dcp_d  = DB[int'(sel_q)*DW +: DW];
            hold_d = hold_q + 8'd1;
          end else begin
            if (mode) begin
              ptr_d  = nextPtr;
              rrBase = nextPtr;
            end
            if ((hold_q >= MaxHold) && (|others)) begin
              arbMask = others;
            end
            pick = arbPick(arbMask, mode, rrBase);
            if (pick[SELW]) begin
              sel_d  = pick[SELW-1:0];
              dcp_d  = DB[int'(pick[SELW-1:0])*DW +: DW];
              hold_d = 8'd1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!MRST) begin
      state_q <= IDLE;
      dcp_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      dcp_q   <= dcp_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign DCP       = dcp_q;
  assign SEL       = sel_q;
  assign dcp_valid = (state_q == SERVE);
  assign grant     = (state_q == SERVE) ? (NCH'(1) << sel_q) : '0;

endmodule

// File: tb/tb_dap_arbiter_n.sv
// Scoreboard bench for dap_arbiter_n: directed scenarios followed by random
// traffic, checked against a behavioural model of the arbitration rules.
module tb_dap_arbiter_n;

  localparam int NCH      = 4;
  localparam int DW       = 32;
  localparam int SELW     = 2;
  localparam int MAX_HOLD = 3;

  logic              clk = 1'b0;
  logic              MRST;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] DB;
  logic              mode;
  logic              lock;
  logic [DW-1:0]     DCP;
  logic [SELW-1:0]   SEL;
  logic              dcp_valid;
  logic              dcp_ready;
  logic [NCH-1:0]    grant;

  typedef struct {
    logic           valid;
    logic [NCH-1:0] grant;
    int             sel;
    logic [DW-1:0]  word;
  } statusT;

  typedef struct {
    int            sel;
    logic [DW-1:0] word;
  } deliveryT;

  statusT   statusQ[$];
  deliveryT deliverQ[$];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: what the port should be showing right now.
  bit            mKnown = 1'b0;
  bit            mBusy;
  int            mCh;
  logic [DW-1:0] mWord;
  int            mPtr;
  int            mHold;

  always #5 clk = ~clk;

  dap_arbiter_n #(
    .NCH(NCH), .DW(DW), .SELW(SELW), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .MRST(MRST), .req(req), .DB(DB), .mode(mode), .lock(lock),
    .DCP(DCP), .SEL(SEL), .dcp_valid(dcp_valid), .dcp_ready(dcp_ready),
    .grant(grant)
  );

  // First requester found scanning the channel list; -1 when none.
  function automatic int pickChannel(logic [NCH-1:0] m, logic rr, int start);
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = rr ? (start + k) % NCH : k;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NCH*DW-1:0] mkBus(logic [DW-1:0] w0, logic [DW-1:0] w1,
                                              logic [DW-1:0] w2, logic [DW-1:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Publish the expected current state, drive one cycle of inputs, and
  // advance the model to the state expected after the coming edge.
  task automatic applyStimulus(input logic rstN, input logic [NCH-1:0] r,
                               input logic md, input logic lk, input logic rdy,
                               input logic [NCH*DW-1:0] bus);
    statusT   s;
    deliveryT d;
    logic [NCH-1:0] m;
    int w;
    @(negedge clk);
    if (mKnown) begin
      s.valid = mBusy;
      s.grant = mBusy ? NCH'(1) << mCh : '0;
      s.sel   = mCh;
      s.word  = mWord;
      statusQ.push_back(s);
    end
    MRST = rstN; req = r; mode = md; lock = lk; dcp_ready = rdy; DB = bus;

    if (!rstN) begin
      mKnown = 1'b1; mBusy = 1'b0; mCh = 0; mWord = '0; mPtr = 0; mHold = 0;
    end else if (mKnown) begin
      if (mBusy && rdy) begin
        d.sel = mCh; d.word = mWord;
        deliverQ.push_back(d);
      end
      if (!mBusy) begin
        w = pickChannel(r, md, mPtr);
        if (w >= 0) begin
          mBusy = 1'b1; mCh = w; mWord = bus[w*DW +: DW]; mHold = 1;
        end
      end else if (rdy) begin
        if (lk && r[mCh] && mHold < MAX_HOLD) begin
          mWord = bus[mCh*DW +: DW];
          mHold++;
        end else begin
          if (md) mPtr = (mCh + 1) % NCH;
          m = r;
          if (mHold >= MAX_HOLD && (r & ~(NCH'(1) << mCh)) != 0)
            m[mCh] = 1'b0;
          w = pickChannel(m, md, mPtr);
          if (w >= 0) begin
            mCh = w; mWord = bus[w*DW +: DW]; mHold = 1;
          end else begin
            mBusy = 1'b0;
          end
        end
      end
    end
  endtask

  // Monitor: just before each rising edge, compare the visible port state
  // and any handshake that is about to complete.
  initial begin
    statusT   s;
    deliveryT d;
    forever begin
      @(negedge clk);
      #4;
      if (statusQ.size() > 0) begin
        s = statusQ.pop_front();
        checkOutput("dcp_valid", DW'(dcp_valid), DW'(s.valid));
        checkOutput("grant", DW'(grant), DW'(s.grant));
        checkOutput("SEL", DW'(SEL), DW'(s.sel));
        checkOutput("DCP", DCP, s.word);
      end
      if (MRST === 1'b1 && dcp_valid === 1'b1 && dcp_ready === 1'b1) begin
        if (deliverQ.size() == 0) begin
          checkOutput("unexpected_delivery", DW'(1), DW'(0));
        end else begin
          d = deliverQ.pop_front();
          checkOutput("delivered_SEL", DW'(SEL), DW'(d.sel));
          checkOutput("delivered_DCP", DCP, d.word);
        end
      end
    end
  end

  // Directed scenarios, then random traffic, then a drain.
  initial begin
    logic [NCH*DW-1:0] bus;
    logic md;
    MRST = 1'b0; req = '0; DB = '0; mode = 1'b0; lock = 1'b0; dcp_ready = 1'b0;

    bus = mkBus(32'h0000_0000, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003);
    repeat (2) applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, bus);
    repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, bus);

    applyStimulus(1'b1, 4'b1010, 1'b0, 1'b0, 1'b1, bus);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, bus);
    repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, bus);

    repeat (9) applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, bus);
    repeat (2) applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, bus);

    bus = mkBus(32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0);
    applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, bus);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, mkBus(32'h0, 32'h0, $urandom, 32'h0));
    repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, bus);

    bus = mkBus(32'hC0C0_0000, 32'hC1C1_0001, 32'h0, 32'h0);
    repeat (7) applyStimulus(1'b1, 4'b0011, 1'b0, 1'b1, 1'b1, bus);
    repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, bus);

    bus = mkBus(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, bus);
    applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, bus);
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, bus);
    repeat (3) applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, bus);

    md = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [NCH-1:0] r;
      if ($urandom_range(0, 9) == 0) md = ~md;
      r = ($urandom_range(0, 4) == 0) ? '0 : NCH'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 99) != 0), r, md,
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7),
                    mkBus($urandom, $urandom, $urandom, $urandom));
    end

    repeat (4) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, bus);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pending_deliveries", DW'(deliverQ.size()), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
